// File: rtl/chan_deinterleave_pkg.sv
// Shared constants and helpers for the channel de-interleaver.
// Default channel count and ADC sample width live here so that instantiating
// code and the bench agree on the baseline build.
package chan_deinterleave_pkg;

  localparam int DEF_NCHAN = 2;
  localparam int DEF_IW    = 12;

  // Frame-sync lock state
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // Ceiling log2, clamped to at least 1 so a counter always has one bit
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/chan_deinterleave_if.sv
// Sample-stream and frame-bus bundle for chan_deinterleave.
// master: ADC capture side (drives samples, receives frames).
// slave : the de-interleaver itself.
interface chan_deinterleave_if
  import chan_deinterleave_pkg::*;
#(
  parameter int NCHAN = DEF_NCHAN,
  parameter int IW    = DEF_IW
);

  logic [IW-1:0]       data_i;
  logic                valid_i;
  logic                sync_i;
  logic [NCHAN*IW-1:0] data_o;
  logic                valid_o;
  logic                chan_err_o;

  modport master (
    output data_i, valid_i, sync_i,
    input  data_o, valid_o, chan_err_o
  );

  modport slave (
    input  data_i, valid_i, sync_i,
    output data_o, valid_o, chan_err_o
  );

endinterface

// File: rtl/chan_deinterleave.sv
// chan_deinterleave: collects a time-multiplexed sample stream (ch0..NCHAN-1)
// into one parallel frame with a single-cycle valid strobe. Locks on sync_i,
// realigns on a misplaced sync and flags it on chan_err_o.
// Optional build switch: FMCW_CHAN_SPLIT_OB2TC_EN inverts each sample MSB at
// capture (offset-binary to two's complement); latency is unchanged.
module chan_deinterleave
  import chan_deinterleave_pkg::*;
#(
  parameter int NCHAN = DEF_NCHAN,
  parameter int IW    = DEF_IW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  chan_deinterleave_if.slave   bus
);

  localparam int CW = cnt_width(NCHAN);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NCHAN - 1);

  lock_state_e         state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [IW-1:0]       stage_reg [NCHAN-1];
  logic [NCHAN*IW-1:0] data_reg;
  logic                valid_reg;
  logic                err_reg;

  logic [IW-1:0]       sample;
  logic [NCHAN*IW-1:0] frame_next;
  logic                wr_en;
  logic [CW-1:0]       wr_slot;

`ifdef FMCW_CHAN_SPLIT_OB2TC_EN
  assign sample = {~bus.data_i[IW-1], bus.data_i[IW-2:0]};
`else
  assign sample = bus.data_i;
`endif

  // Staging write: a sync (any state) or a frame start goes to slot 0;
  // mid-frame samples go to slot cnt; the last sample bypasses staging.
  always_comb begin
    wr_en   = 1'b0;
    wr_slot = '0;
    if (bus.valid_i) begin
      if (bus.sync_i || (state_reg == ST_LOCKED && cnt_reg == '0)) begin
        wr_en   = 1'b1;
        wr_slot = '0;
      end else if (state_reg == ST_LOCKED && cnt_reg != LAST_SLOT) begin
        wr_en   = 1'b1;
        wr_slot = cnt_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN - 1; gi++) begin : g_stage
      // Per-slot staging register; contents are don't-care out of reset
      always_ff @(posedge clk_i) begin
        if (wr_en && wr_slot == CW'(gi)) stage_reg[gi] <= sample;
      end
      assign frame_next[gi*IW +: IW] = stage_reg[gi];
    end
  endgenerate

  assign frame_next[(NCHAN-1)*IW +: IW] = sample;

  // Lock FSM, slot counter and registered frame/strobe outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_UNLOCKED;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      if (bus.valid_i) begin
        case (state_reg)
          ST_UNLOCKED: begin
            if (bus.sync_i) begin
              state_reg <= ST_LOCKED;
              cnt_reg   <= CW'(1);
            end
          end
          default: begin
            if (cnt_reg == '0) begin
              cnt_reg <= CW'(1);
            end else if (bus.sync_i) begin
              // Misplaced sync: drop the partial frame and restart from it
              cnt_reg <= CW'(1);
              err_reg <= 1'b1;
            end else if (cnt_reg == LAST_SLOT) begin
              data_reg  <= frame_next;
              valid_reg <= 1'b1;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign bus.data_o     = data_reg;
  assign bus.valid_o    = valid_reg;
  assign bus.chan_err_o = err_reg;

endmodule

// File: doc/chan_deinterleave.md
# chan_deinterleave

Parametrised de-interleaver for the FMCW receive path. It accepts a time-multiplexed sample stream (channel 0, 1, …, NCHAN-1, repeating) from the ADC capture logic and presents all channels of one frame in parallel on a flattened output bus with a single-cycle valid strobe. It sits between ADC capture and the per-channel downconversion/FIR chains. It generalises the fixed two-channel splitter to arbitrary channel count and sample width, and adds frame-sync lock, realignment and error reporting.

## Interface
Parameters:
- NCHAN, 2, number of interleaved channels; legal range ≥ 2.
- IW, 12, sample width in bits.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- data_i  input  IW  interleaved sample.
- valid_i  input  1  data_i carries a sample this cycle.
- sync_i  input  1  qualifies data_i as channel 0; ignored when valid_i=0.
- data_o  output  NCHAN*IW  channel k in bits [k*IW +: IW].
- valid_o  output  1  one-cycle strobe; data_o holds a new complete frame.
- chan_err_o  output  1  one-cycle strobe; misaligned sync detected.

## Operation
- State: locked flag; slot counter cnt, width max(1, clog2(NCHAN)), range 0..NCHAN-1; NCHAN-1 staging registers of IW bits (slots 0..NCHAN-2).
- UNLOCKED (after reset): valid samples without sync_i are discarded. valid_i & sync_i → store in slot 0, cnt←1, enter LOCKED.
- LOCKED, valid_i=1:
  - cnt=0: store in slot 0, cnt←1. sync_i optional here.
  - 0<cnt<NCHAN-1, sync_i=0: store in slot cnt, cnt←cnt+1.
  - cnt=NCHAN-1, sync_i=0: data_o←{data_i, slots NCHAN-2..0}, valid_o←1, cnt←0.
  - cnt≠0, sync_i=1: realign. Discard the partial frame, store the sample in slot 0, cnt←1, chan_err_o←1. No valid_o.
- valid_i=0: no state change. Gaps between samples of one frame are allowed, with no timeout.
- data_o changes only on a frame-complete update and holds otherwise.
- Arithmetic: samples are stored unchanged, except for the transform under Configuration. No width growth.

## Timing
- Reset values: data_o=0, valid_o=0, chan_err_o=0, cnt=0, locked=0. Staging contents are don't-care.
- Latency: last sample of a frame accepted on edge t → data_o/valid_o visible after edge t+1, i.e. registered, 1 cycle.
- Throughput: one sample per cycle sustained. Frame-complete and the next frame's slot-0 sample may arrive on consecutive cycles.
- valid_o and chan_err_o are never asserted together.
- rst_i mid-frame: partial frame is dropped, lock is lost, and any pending strobes are cleared on the same edge.
- rst_i has priority over all inputs.

## Configuration
- FMCW_CHAN_SPLIT_OB2TC_EN defined: every sample has its MSB inverted at capture, converting offset-binary ADC codes to two's complement. Example: 12'h800 → 12'h000, 12'h000 → 12'h800.
- Not defined: samples pass through bit-exact.
- Latency is identical in both builds.

## Structure
- Shared defines go in fmcw_defines.vh:
  - default NCHAN and IW (ADC width) constants;
  - the FMCW_CHAN_SPLIT_OB2TC_EN switch.
- Single module; no sub-module is warranted. Counter, lock flag and staging are local.
- Compute the counter width with a local clog2 function, clamped to a minimum of 1.

## Test plan
- NCHAN=2, IW=12, no macro: after reset send (sync,0x111), (0x222), (sync,0x333), (0x444). Expect valid_o on 2 strobes, data_o=0x222111 then 0x444333, chan_err_o=0.
- Before lock, send 5 samples with sync_i=0. Expect no valid_o. Then a synced frame yields exactly one valid_o.
- NCHAN=4: send ch0, ch1, then sync on the 3rd sample. Expect chan_err_o pulse, no valid_o. The following 3 samples complete the frame with the realigned data.
- NCHAN=4: insert 3 idle cycles between each sample. Expect correct frame and valid_o exactly 1 cycle after the 4th sample.
- Assert rst_i after 2 of 4 samples. Expect outputs at 0 and lock lost; subsequent unsynced samples produce nothing.
- Macro defined, NCHAN=2: frame 0x800, 0xFFF. Expect data_o = {12'h7FF, 12'h000}.
